console_key_receiver: RTL and testbench
=======================================

# console_key_receiver

Input-side counterpart of the console lamp drivers: receives raw, active-low operator key/switch contacts from the 1620 console panel and delivers clean logic-level signals to control logic. Per key, it synchronizes and debounces the contact, and produces a level plus one-cycle press/release pulses. Press events are buffered in a pending mask and presented one at a time, lowest index first, through a valid/ack event register.

## Interface
- N_KEYS, 8: number of console key contacts (1..16).
- DEBOUNCE_CYCLES, 16: consecutive stable synchronized samples required to accept a change (≥2).
- clk  input  1  system clock; all state on rising edge.
- rst_n  input  1  asynchronous, active-low reset.
- key_n  input  N_KEYS  raw contacts, active low; 1 or z (open contact, pull-up) = released, 0 = pressed.
- key_level  output  N_KEYS  debounced state, 1 = pressed.
- key_press  output  N_KEYS  one-cycle pulse when key_level rises.
- key_release  output  N_KEYS  one-cycle pulse when key_level falls.
- any_pressed  output  1  OR of key_level.
- event_valid  output  1  event register holds an unacknowledged press.
- event_code  output  $clog2(N_KEYS) (min 1)  index of buffered key; holds while event_valid.
- event_ack  input  1  consumer accepts event; meaningful only when event_valid.
- overrun  output  1  sticky: a press arrived for a key whose pending bit was already set.

## Operation
- Input conditioning: each bit of key_n is converted with pull-up semantics (0 → pressed, 1/z/x → released), then passed through a 2-flop synchronizer.
- Debounce per key: a counter clears whenever the synchronized sample equals key_level, and increments otherwise. When it reaches DEBOUNCE_CYCLES, key_level toggles and the counter clears. Counter width is $clog2(DEBOUNCE_CYCLES+1); it never wraps.
- Pulses: key_press/key_release are registered and are high in the same cycle key_level changes.
- Pending mask (N_KEYS bits):
  - The bit is set on key_press.
  - The bit is cleared when that key is loaded into the event register.
  - If a key_press hits a bit that is already set, overrun is set; the press is merged, not queued twice.
- Event register:
  - When empty, or in the cycle event_ack is accepted, it loads the lowest set pending index, and event_valid stays or becomes 1.
  - If the mask is empty, event_valid goes 0.
- Simultaneous events:
  - A key_press for key k in the same cycle k is loaded sets pending k again (set wins); overrun is not flagged.
  - event_ack while event_valid=0 is ignored.
- overrun clears only on reset.

## Timing
- Reset values:
  - key_level, key_press, key_release, any_pressed, event_valid, overrun: 0.
  - event_code: 0; pending mask: 0; counters: 0.
  - Synchronizer flops: released.
- Raw edge to key_level change: the synchronized sample changes 2 edges after the raw change is captured; key_level changes DEBOUNCE_CYCLES edges later. Total latency: 2+DEBOUNCE_CYCLES cycles.
- Bounce shorter than DEBOUNCE_CYCLES consecutive samples produces no level change and no pulse.
- Event path:
  - Pending bit is set at the edge where key_press is high.
  - event_valid rises 1 cycle later.
  - Back-to-back: with ack held high and the mask non-empty, a new event is presented every cycle.
- Keys held through reset deassertion produce a key_press after 2+DEBOUNCE_CYCLES cycles (intentional: console shows the true switch state).
- Reset asserted mid-debounce or mid-handshake aborts everything immediately. Pending events are discarded.

## Structure
- Shared package console_pkg holds:
  - default N_KEYS and DEBOUNCE_CYCLES;
  - key index constants (KEY_START=0, KEY_STOP=1, KEY_RESET=2, KEY_INSERT=3, KEY_RELEASE=4, KEY_SIE=5, KEY_SCE=6, KEY_DISPLAY_MAR=7);
  - the pull-up conversion function, shared with the SMS card models.
- Sub-module key_debounce (synchronizer + counter + level + pulses, one key) is instantiated N_KEYS times via generate.
- The pending mask, priority select and event register live in the top.

## Test plan
All scenarios use N_KEYS=4, DEBOUNCE_CYCLES=4.
- Reset with all key_n=z → all outputs 0. Hold 20 cycles → no pulses.
- key_n[1] driven 0 and held → key_press[1] high for exactly 1 cycle and key_level[1]=1, 6 cycles after capture; 1 cycle later event_valid=1, event_code=1. Ack → event_valid=0.
- key_n[2] bounces 0,1,0,1 (1 cycle each), then holds 0 → single key_press[2], 6 cycles after the final stable 0.
- Keys 3 and 0 pressed in the same cycle, ack withheld → event_code=0 first. On ack, the next cycle shows event_code=3. After a second ack, event_valid=0.
- Key 1 pressed, released, pressed again with no ack → overrun=1, pending[1] a single bit. Only one further event for key 1 after the current ack.
- rst_n pulsed low mid-debounce with key 0 held → outputs 0 immediately. After release, key_press[0] fires 6 cycles later.

Source files
------------

// File: rtl/console_pkg.sv
// -----------------------------------------------------------------------------
// console_pkg
// Shared definitions for the 1620 console panel key path: default sizing,
// symbolic key indices and the pull-up contact conversion also used by the
// SMS card models.
// -----------------------------------------------------------------------------
package console_pkg;

  localparam int N_KEYS_DEFAULT          = 8;
  localparam int DEBOUNCE_CYCLES_DEFAULT = 16;

  // Console key positions on the key_n bus.
  localparam int KEY_START       = 0;
  localparam int KEY_STOP        = 1;
  localparam int KEY_RESET       = 2;
  localparam int KEY_INSERT      = 3;
  localparam int KEY_RELEASE     = 4;
  localparam int KEY_SIE         = 5;
  localparam int KEY_SCE         = 6;
  localparam int KEY_DISPLAY_MAR = 7;

  // Active-low contact with pull-up: only a solid 0 means pressed; an open
  // contact (z) or an undriven/unknown line reads as released.
  function automatic logic pull_up_pressed(input logic raw_n);
    return (raw_n === 1'b0);
  endfunction

endpackage

// File: rtl/key_debounce.sv
// -----------------------------------------------------------------------------
// key_debounce
// One console key: pull-up conversion, 2-flop synchronizer, stability counter,
// debounced level and one-cycle press/release pulses.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_n        : raw active-low contact
//   key_level    : debounced state, 1 = pressed
//   key_press    : registered pulse in the cycle key_level rises
//   key_release  : registered pulse in the cycle key_level falls
//   press_next   : combinational, high in the cycle before key_press, so the
//                  top can capture the press on the same edge as key_press
// -----------------------------------------------------------------------------
module key_debounce
  import console_pkg::*;
#(
  parameter int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT
) (
  input  logic clk,
  input  logic rst_n,
  input  logic key_n,
  output logic key_level,
  output logic key_press,
  output logic key_release,
  output logic press_next
);

  localparam int CNT_W = $clog2(DEBOUNCE_CYCLES + 1);

  logic [1:0]       sync_q;
  logic             sample;
  logic [CNT_W-1:0] cnt_q;
  logic             toggle;

  assign sample = sync_q[1];

  // The counter already holds DEBOUNCE_CYCLES-1 differing samples, so the
  // current differing sample is the DEBOUNCE_CYCLES-th: accept the change now.
  assign toggle     = (sample != key_level) && (cnt_q == CNT_W'(DEBOUNCE_CYCLES - 1));
  assign press_next = toggle && !key_level;

  // NOTE: sequential state uses non-blocking assignments so every flop samples
  // the pre-edge value of its neighbours (the synchronizer chain relies on it).
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      sync_q      <= '0;
      cnt_q       <= '0;
      key_level   <= 1'b0;
      key_press   <= 1'b0;
      key_release <= 1'b0;
    end else begin
      sync_q <= {sync_q[0], pull_up_pressed(key_n)};

      if (sample == key_level || toggle) begin
        cnt_q <= '0;
      end else begin
        cnt_q <= cnt_q + 1'b1;
      end

      if (toggle) begin
        key_level <= ~key_level;
      end
      key_press   <= press_next;
      key_release <= toggle && key_level;
    end
  end

endmodule

// File: rtl/console_key_receiver.sv
// -----------------------------------------------------------------------------
// console_key_receiver
// Debounces N_KEYS active-low console contacts and queues press events.
// Presses are merged into a pending mask and presented one at a time, lowest
// index first, through a valid/ack event register.
//   clk, rst_n   : clock, asynchronous active-low reset
//   key_n        : raw contacts, active low (open = released)
//   key_level    : debounced level per key, 1 = pressed
//   key_press    : one-cycle pulse per key when key_level rises
//   key_release  : one-cycle pulse per key when key_level falls
//   any_pressed  : OR of key_level
//   event_valid  : event register holds an unacknowledged press
//   event_code   : index of the buffered key
//   event_ack    : consumer accepts the current event
//   overrun      : sticky, a press merged into an already pending key
// -----------------------------------------------------------------------------
module console_key_receiver
  import console_pkg::*;
#(
  parameter  int N_KEYS          = N_KEYS_DEFAULT,
  parameter  int DEBOUNCE_CYCLES = DEBOUNCE_CYCLES_DEFAULT,
  localparam int CODE_W          = (N_KEYS > 1) ? $clog2(N_KEYS) : 1
) (
  input  logic              clk,
  input  logic              rst_n,
  input  logic [N_KEYS-1:0] key_n,
  output logic [N_KEYS-1:0] key_level,
  output logic [N_KEYS-1:0] key_press,
  output logic [N_KEYS-1:0] key_release,
  output logic              any_pressed,
  output logic              event_valid,
  output logic [CODE_W-1:0] event_code,
  input  logic              event_ack,
  output logic              overrun
);

  logic [N_KEYS-1:0] press_next;
  logic [N_KEYS-1:0] pending_q;
  logic [N_KEYS-1:0] load_mask;
  logic [CODE_W-1:0] sel_code;
  logic              pending_any;
  logic              load;

  for (genvar i = 0; i < N_KEYS; i++) begin : g_key
    key_debounce #(
      .DEBOUNCE_CYCLES (DEBOUNCE_CYCLES)
    ) u_debounce (
      .clk         (clk),
      .rst_n       (rst_n),
      .key_n       (key_n[i]),
      .key_level   (key_level[i]),
      .key_press   (key_press[i]),
      .key_release (key_release[i]),
      .press_next  (press_next[i])
    );
  end

  assign any_pressed = |key_level;
  assign pending_any = |pending_q;

  // An ack while the register is empty is harmless: the register loads
  // whenever it is empty anyway.
  assign load = !event_valid || event_ack;

  // Lowest set index wins: scan downwards so the last hit is the lowest.
  // NOTE: every always_comb output gets a default first, so no path can hold
  // an old value and infer a latch.
  always_comb begin
    sel_code = '0;
    for (int i = N_KEYS - 1; i >= 0; i--) begin
      if (pending_q[i]) begin
        sel_code = CODE_W'(i);
      end
    end
  end

  always_comb begin
    load_mask = '0;
    for (int i = 0; i < N_KEYS; i++) begin
      load_mask[i] = load && pending_q[i] && (sel_code == CODE_W'(i));
    end
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      pending_q   <= '0;
      event_valid <= 1'b0;
      event_code  <= '0;
      overrun     <= 1'b0;
    end else begin
      // A new press on the key being loaded this cycle re-arms it (set wins)
      // and is a fresh event, not an overrun.
      pending_q <= (pending_q & ~load_mask) | press_next;

      if (|(press_next & pending_q & ~load_mask)) begin
        overrun <= 1'b1;
      end

      if (load) begin
        event_valid <= pending_any;
        if (pending_any) begin
          event_code <= sel_code;
        end
      end
    end
  end

endmodule

// File: tb/tb_console_key_receiver.sv
// -----------------------------------------------------------------------------
// tb_console_key_receiver
// Self-checking bench for console_key_receiver with N_KEYS=4,
// DEBOUNCE_CYCLES=4 (press latency 6 cycles). Expected event codes are queued
// when keys are pressed and popped when the DUT presents the event.
// Released contacts are driven as 1, which the pull-up conversion treats the
// same as an open (z) contact.
// -----------------------------------------------------------------------------
module tb_console_key_receiver;

  localparam int NK  = 4;
  localparam int DB  = 4;
  localparam int LAT = 2 + DB;

  logic          clk = 1'b0;
  logic          rst_n;
  logic [NK-1:0] key_n;
  logic [NK-1:0] key_level;
  logic [NK-1:0] key_press;
  logic [NK-1:0] key_release;
  logic          any_pressed;
  logic          event_valid;
  logic [1:0]    event_code;
  logic          event_ack;
  logic          overrun;

  int tests_run    = 0;
  int tests_failed = 0;
  int exp_q[$];

  console_key_receiver #(
    .N_KEYS          (NK),
    .DEBOUNCE_CYCLES (DB)
  ) dut (
    .clk         (clk),
    .rst_n       (rst_n),
    .key_n       (key_n),
    .key_level   (key_level),
    .key_press   (key_press),
    .key_release (key_release),
    .any_pressed (any_pressed),
    .event_valid (event_valid),
    .event_code  (event_code),
    .event_ack   (event_ack),
    .overrun     (overrun)
  );

  always #5 clk = ~clk;

  // Advance n rising edges and land 1 time unit after the last one; inputs
  // are driven and outputs sampled at that point.
  task automatic tick(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic test_reset;
    rst_n     = 1'b0;
    key_n     = '1;
    event_ack = 1'b0;
    exp_q.delete();
    tick(2);
    tests_run++;
    if ({key_level, key_press, key_release, any_pressed, event_valid, event_code, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL reset_outputs: got lvl=%b prs=%b rel=%b any=%b vld=%b code=%0d ovr=%b, want all 0",
               key_level, key_press, key_release, any_pressed, event_valid, event_code, overrun);
    end
    rst_n = 1'b1;
    for (int c = 0; c < 20; c++) begin
      tick(1);
      tests_run++;
      if ({key_level, key_press, key_release, event_valid} !== '0) begin
        tests_failed++;
        $display("FAIL idle_quiet cycle %0d: got lvl=%b prs=%b rel=%b vld=%b, want all 0",
                 c, key_level, key_press, key_release, event_valid);
      end
    end
  endtask

  task automatic test_single_press;
    int e;
    key_n[1] = 1'b0;
    exp_q.push_back(1);
    for (int c = 1; c <= LAT + 1; c++) begin
      tick(1);
      tests_run++;
      if (key_press !== ((c == LAT) ? 4'b0010 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL single_press_pulse cycle %0d: got %b want %b", c, key_press,
                 (c == LAT) ? 4'b0010 : 4'b0000);
      end
    end
    tests_run++;
    if (key_level !== 4'b0010 || any_pressed !== 1'b1) begin
      tests_failed++;
      $display("FAIL single_press_level: got lvl=%b any=%b want 0010/1", key_level, any_pressed);
    end
    tests_run++;
    if (event_valid !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL single_event_valid: got %b want 1 (queued %0d)", event_valid, exp_q.size());
    end else begin
      e = exp_q.pop_front();
      if (event_code !== 2'(e)) begin
        tests_failed++;
        $display("FAIL single_event_code: got %0d want %0d", event_code, e);
      end
    end
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    tests_run++;
    if (event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_after_ack: got valid=%b want 0", event_valid);
    end
    key_n[1] = 1'b1;
    tick(LAT);
    tests_run++;
    if (key_release !== 4'b0010 || key_level !== 4'b0000 || event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL single_release: got rel=%b lvl=%b vld=%b want 0010/0000/0", key_release, key_level, event_valid);
    end
    tick(2);
  endtask

  task automatic test_bounce;
    int e;
    for (int b = 0; b < 4; b++) begin
      key_n[2] = b[0];
      tick(1);
      tests_run++;
      if (key_press !== 4'b0000) begin
        tests_failed++;
        $display("FAIL bounce_glitch step %0d: got press=%b want 0000", b, key_press);
      end
    end
    key_n[2] = 1'b0;
    exp_q.push_back(2);
    for (int c = 1; c <= LAT; c++) begin
      tick(1);
      tests_run++;
      if (key_press !== ((c == LAT) ? 4'b0100 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL bounce_press cycle %0d: got %b want %b", c, key_press,
                 (c == LAT) ? 4'b0100 : 4'b0000);
      end
    end
    tick(1);
    tests_run++;
    if (event_valid !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL bounce_event_valid: got %b want 1", event_valid);
    end else begin
      e = exp_q.pop_front();
      if (event_code !== 2'(e)) begin
        tests_failed++;
        $display("FAIL bounce_event_code: got %0d want %0d", event_code, e);
      end
    end
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    key_n[2]  = 1'b1;
    tick(LAT + 2);
    tests_run++;
    if (key_level !== 4'b0000 || event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL bounce_settle: got lvl=%b vld=%b want 0000/0", key_level, event_valid);
    end
  endtask

  task automatic test_simultaneous;
    int e;
    key_n[3] = 1'b0;
    key_n[0] = 1'b0;
    exp_q.push_back(0);
    exp_q.push_back(3);
    tick(LAT);
    tests_run++;
    if (key_press !== 4'b1001) begin
      tests_failed++;
      $display("FAIL simul_press: got %b want 1001", key_press);
    end
    tick(1);
    tests_run++;
    if (event_valid !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL simul_first_valid: got %b want 1", event_valid);
    end else begin
      e = exp_q.pop_front();
      if (event_code !== 2'(e)) begin
        tests_failed++;
        $display("FAIL simul_first_code: got %0d want %0d", event_code, e);
      end
    end
    tick(2);
    tests_run++;
    if (event_valid !== 1'b1 || event_code !== 2'd0) begin
      tests_failed++;
      $display("FAIL simul_hold: got vld=%b code=%0d want 1/0", event_valid, event_code);
    end
    event_ack = 1'b1;
    tick(1);
    tests_run++;
    if (event_valid !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL simul_second_valid: got %b want 1", event_valid);
    end else begin
      e = exp_q.pop_front();
      if (event_code !== 2'(e)) begin
        tests_failed++;
        $display("FAIL simul_second_code: got %0d want %0d", event_code, e);
      end
    end
    tick(1);
    tests_run++;
    if (event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL simul_drained: got valid=%b want 0", event_valid);
    end
    tick(1);
    event_ack = 1'b0;
    key_n     = '1;
    tick(LAT + 2);
  endtask

  task automatic test_overrun;
    int e;
    // Park key 2 in the event register so key 1 presses stay pending.
    key_n[2] = 1'b0;
    exp_q.push_back(2);
    tick(LAT + 1);
    tests_run++;
    if (event_valid !== 1'b1 || event_code !== 2'd2) begin
      tests_failed++;
      $display("FAIL ovr_park: got vld=%b code=%0d want 1/2", event_valid, event_code);
    end
    key_n[1] = 1'b0;
    exp_q.push_back(1);
    tick(LAT);
    key_n[1] = 1'b1;
    tick(LAT);
    tests_run++;
    if (overrun !== 1'b0 || key_release !== 4'b0010) begin
      tests_failed++;
      $display("FAIL ovr_first_press: got ovr=%b rel=%b want 0/0010", overrun, key_release);
    end
    key_n[1] = 1'b0;
    tick(LAT + 1);
    tests_run++;
    if (overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_flag: got %b want 1", overrun);
    end
    // Ack key 2, then key 1 must appear exactly once.
    for (int k = 0; k < 2; k++) begin
      tests_run++;
      if (event_valid !== 1'b1 || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL ovr_event_valid %0d: got %b want 1", k, event_valid);
      end else begin
        e = exp_q.pop_front();
        if (event_code !== 2'(e)) begin
          tests_failed++;
          $display("FAIL ovr_event_code %0d: got %0d want %0d", k, event_code, e);
        end
      end
      event_ack = 1'b1;
      tick(1);
      event_ack = 1'b0;
    end
    tests_run++;
    if (event_valid !== 1'b0 || overrun !== 1'b1) begin
      tests_failed++;
      $display("FAIL ovr_single_merge: got vld=%b ovr=%b want 0/1", event_valid, overrun);
    end
    key_n = '1;
    tick(LAT + 2);
  endtask

  task automatic test_back_to_back;
    int e;
    event_ack = 1'b1;
    key_n     = '0;
    for (int k = 0; k < NK; k++) exp_q.push_back(k);
    tick(LAT + 1);
    for (int k = 0; k < NK; k++) begin
      tests_run++;
      if (event_valid !== 1'b1 || exp_q.size() == 0) begin
        tests_failed++;
        $display("FAIL b2b_valid %0d: got %b want 1", k, event_valid);
      end else begin
        e = exp_q.pop_front();
        if (event_code !== 2'(e)) begin
          tests_failed++;
          $display("FAIL b2b_code %0d: got %0d want %0d", k, event_code, e);
        end
      end
      tick(1);
    end
    tests_run++;
    if (event_valid !== 1'b0) begin
      tests_failed++;
      $display("FAIL b2b_drained: got valid=%b want 0", event_valid);
    end
    event_ack = 1'b0;
    key_n     = '1;
    tick(LAT + 2);
  endtask

  task automatic test_reset_mid;
    int e;
    key_n[0] = 1'b0;
    tick(3);
    rst_n = 1'b0;
    exp_q.delete();
    #1;
    tests_run++;
    if ({key_level, key_press, key_release, any_pressed, event_valid, event_code, overrun} !== '0) begin
      tests_failed++;
      $display("FAIL mid_reset_outputs: got lvl=%b prs=%b vld=%b code=%0d ovr=%b, want all 0",
               key_level, key_press, event_valid, event_code, overrun);
    end
    tick(2);
    rst_n = 1'b1;
    exp_q.push_back(0);
    for (int c = 1; c <= LAT; c++) begin
      tick(1);
      tests_run++;
      if (key_press !== ((c == LAT) ? 4'b0001 : 4'b0000)) begin
        tests_failed++;
        $display("FAIL mid_reset_press cycle %0d: got %b want %b", c, key_press,
                 (c == LAT) ? 4'b0001 : 4'b0000);
      end
    end
    tick(1);
    tests_run++;
    if (event_valid !== 1'b1 || exp_q.size() == 0) begin
      tests_failed++;
      $display("FAIL mid_reset_event_valid: got %b want 1", event_valid);
    end else begin
      e = exp_q.pop_front();
      if (event_code !== 2'(e)) begin
        tests_failed++;
        $display("FAIL mid_reset_event_code: got %0d want %0d", event_code, e);
      end
    end
    event_ack = 1'b1;
    tick(1);
    event_ack = 1'b0;
    tests_run++;
    if (event_valid !== 1'b0 || exp_q.size() != 0) begin
      tests_failed++;
      $display("FAIL final_drain: got valid=%b queued=%0d want 0/0", event_valid, exp_q.size());
    end
  endtask

  initial begin
    test_reset();
    test_single_press();
    test_bounce();
    test_simultaneous();
    test_overrun();
    test_back_to_back();
    test_reset_mid();
    $display("[TB] %0d tests run, %0d failed", tests_run, tests_failed);
    $finish;
  end

endmodule
